// File: rtl/fb_mem_pkg.sv
// Shared encodings and default widths for the framebuffer memory arbiter.
package fb_mem_pkg;

  localparam int FB_ADDR_WIDTH = 17;
  localparam int FB_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } arbState_t;

  typedef enum logic [1:0] {
    OWN_HDMI  = 2'd0,
    OWN_GPU   = 2'd1,
    OWN_CLEAR = 2'd2
  } owner_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Walks every word of one framebuffer bank, presenting a fill write per word;
// the arbiter strobes advance when each write is accepted.
module fb_clear_engine
  import fb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] colour,
  input  logic                  bank,
  input  logic                  advance,
  output logic                  busy,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  clearBank
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

  logic                  busyReg;
  logic [ADDR_WIDTH-1:0] countReg;
  logic [DATA_WIDTH-1:0] colourReg;
  logic                  bankReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyReg   <= 1'b0;
      countReg  <= '0;
      colourReg <= '0;
      bankReg   <= 1'b0;
    end else if (!busyReg) begin
      if (start) begin
        busyReg   <= 1'b1;
        countReg  <= '0;
        colourReg <= colour;
        bankReg   <= bank;
      end
    end else if (advance) begin
      // Counter wraps back to zero on the final word, ready for the next clear.
      if (countReg == LAST_WORD) begin
        busyReg <= 1'b0;
      end
      countReg <= countReg + ADDR_WIDTH'(1);
    end
  end

  assign busy      = busyReg;
  assign req       = busyReg;
  assign addr      = countReg;
  assign wdata     = colourReg;
  assign clearBank = bankReg;

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer arbiter: HDMI scanout has priority, GPU and clear
// engine share the remaining slots round-robin; one transaction in flight.
module fb_mem_arbiter
  import fb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fbGPU,
  input  logic                  fbHDMI,
  input  logic                  hdmi_req,
  input  logic [ADDR_WIDTH-1:0] hdmi_addr,
  output logic                  hdmi_gnt,
  output logic                  hdmi_rvalid,
  input  logic                  gpu_req,
  input  logic                  gpu_we,
  input  logic [ADDR_WIDTH-1:0] gpu_addr,
  input  logic [DATA_WIDTH-1:0] gpu_wdata,
  output logic                  gpu_gnt,
  output logic                  gpu_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_colour,
  output logic                  clear_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arbState_t             stateReg, stateNext;
  owner_t                ownerReg, ownerNext;
  logic                  favourClearReg, favourClearNext;
  logic                  memReqReg, memReqNext;
  logic                  memWeReg, memWeNext;
  logic [ADDR_WIDTH:0]   memAddrReg, memAddrNext;
  logic [DATA_WIDTH-1:0] memWdataReg, memWdataNext;

  logic                  clearReq;
  logic [ADDR_WIDTH-1:0] clearAddr;
  logic [DATA_WIDTH-1:0] clearWdata;
  logic                  clearBank;
  logic                  clearAdvance;
  logic                  ackNow;
  logic                  rvalidNow;

  fb_clear_engine #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) clearEngine (
    .clk      (clk),
    .reset    (reset),
    .start    (clear_start),
    .colour   (clear_colour),
    .bank     (fbGPU),
    .advance  (clearAdvance),
    .busy     (clear_busy),
    .req      (clearReq),
    .addr     (clearAddr),
    .wdata    (clearWdata),
    .clearBank(clearBank)
  );

  assign ackNow       = (stateReg == ST_ISSUE) && mem_ack;
  assign rvalidNow    = (stateReg == ST_RDATA) && mem_rvalid;
  assign hdmi_gnt     = ackNow && (ownerReg == OWN_HDMI);
  assign gpu_gnt      = ackNow && (ownerReg == OWN_GPU);
  assign clearAdvance = ackNow && (ownerReg == OWN_CLEAR);
  assign hdmi_rvalid  = rvalidNow && (ownerReg == OWN_HDMI);
  assign gpu_rvalid   = rvalidNow && (ownerReg == OWN_GPU);
  assign rdata        = mem_rdata;

  assign mem_req   = memReqReg;
  assign mem_we    = memWeReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;

  always_comb begin
    stateNext       = stateReg;
    ownerNext       = ownerReg;
    favourClearNext = favourClearReg;
    memReqNext      = memReqReg;
    memWeNext       = memWeReg;
    memAddrNext     = memAddrReg;
    memWdataNext    = memWdataReg;

    case (stateReg)
      ST_IDLE: begin
        // Bank bits are captured here so a later buffer swap cannot retarget
        // a transaction that has already been selected.
        if (hdmi_req) begin
          ownerNext   = OWN_HDMI;
          memWeNext   = 1'b0;
          memAddrNext = {fbHDMI, hdmi_addr};
          memReqNext  = 1'b1;
          stateNext   = ST_ISSUE;
        end else if (gpu_req && (!clearReq || !favourClearReg)) begin
          ownerNext       = OWN_GPU;
          memWeNext       = gpu_we;
          memAddrNext     = {fbGPU, gpu_addr};
          memWdataNext    = gpu_wdata;
          memReqNext      = 1'b1;
          favourClearNext = !favourClearReg;
          stateNext       = ST_ISSUE;
        end else if (clearReq) begin
          ownerNext       = OWN_CLEAR;
          memWeNext       = 1'b1;
          memAddrNext     = {clearBank, clearAddr};
          memWdataNext    = clearWdata;
          memReqNext      = 1'b1;
          favourClearNext = !favourClearReg;
          stateNext       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          memReqNext = 1'b0;
          stateNext  = memWeReg ? ST_IDLE : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (mem_rvalid) begin
          stateNext = ST_IDLE;
        end
      end
      default: begin
        stateNext  = ST_IDLE;
        memReqNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg       <= ST_IDLE;
      ownerReg       <= OWN_GPU;
      favourClearReg <= 1'b0;
      memReqReg      <= 1'b0;
      memWeReg       <= 1'b0;
      memAddrReg     <= '0;
      memWdataReg    <= '0;
    end else begin
      stateReg       <= stateNext;
      ownerReg       <= ownerNext;
      favourClearReg <= favourClearNext;
      memReqReg      <= memReqNext;
      memWeReg       <= memWeNext;
      memAddrReg     <= memAddrNext;
      memWdataReg    <= memWdataNext;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: directed scenarios plus a randomized
// phase checked against a memory/scoreboard model kept in the bench.
module tb_fb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int MW = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          fbGPU, fbHDMI;
  logic          hdmi_req;
  logic [AW-1:0] hdmi_addr;
  logic          hdmi_gnt, hdmi_rvalid;
  logic          gpu_req, gpu_we;
  logic [AW-1:0] gpu_addr;
  logic [DW-1:0] gpu_wdata;
  logic          gpu_gnt, gpu_rvalid;
  logic [DW-1:0] rdata;
  logic          clear_start;
  logic [DW-1:0] clear_colour;
  logic          clear_busy;
  logic          mem_req, mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .fbGPU(fbGPU), .fbHDMI(fbHDMI),
    .hdmi_req(hdmi_req), .hdmi_addr(hdmi_addr), .hdmi_gnt(hdmi_gnt), .hdmi_rvalid(hdmi_rvalid),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .rdata(rdata),
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_busy(clear_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW:0]   addr;
    logic [DW-1:0] wdata;
  } memTxn_t;

  memTxn_t       txnLog[$];
  logic [DW-1:0] memArr [MW];
  logic [DW-1:0] refMem [MW];

  // Memory responder knobs
  logic fixedAck = 1'b0;
  logic noAck = 1'b0;
  logic injectSpurious = 1'b0;
  int   rdLat = -1;

  logic          ackWe;
  logic [AW:0]   ackAddr;
  logic [DW-1:0] ackWdata;
  logic          rdPending = 1'b0;
  int            rdCnt;
  logic [AW:0]   rdAddr;

  initial begin
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (reset) begin
      mem_ack = 1'b0;
      rdPending = 1'b0;
    end else begin
      if (mem_ack) begin
        txnLog.push_back('{ackWe, ackAddr, ackWdata});
        if (ackWe) memArr[ackAddr] = ackWdata;
        else begin
          rdPending = 1'b1;
          rdAddr = ackAddr;
          rdCnt = (rdLat < 0) ? int'($urandom_range(0, 3)) : rdLat;
        end
      end
      if (rdPending) begin
        if (rdCnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = memArr[rdAddr];
          rdPending = 1'b0;
        end else rdCnt--;
      end else if (injectSpurious) begin
        mem_rvalid = 1'b1;
        mem_rdata = 16'hDEAD;
        injectSpurious = 1'b0;
      end
      mem_ack = mem_req && !noAck && (fixedAck || ($urandom_range(0, 2) != 0));
      if (mem_ack) begin
        ackWe = mem_we;
        ackAddr = mem_addr;
        ackWdata = mem_wdata;
      end
    end
  end

  int            nAssert = 0;
  int            nFail = 0;
  int            cyc = 0;
  int            hdmiGnts, gpuGnts, hdmiRvs, gpuRvs, gpuGntCyc, gpuRvCyc;
  logic [DW-1:0] hdmiData, gpuData;
  logic          gpuHold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounters();
    hdmiGnts = 0; gpuGnts = 0; hdmiRvs = 0; gpuRvs = 0;
    gpuGntCyc = 0; gpuRvCyc = 0; hdmiData = '0; gpuData = '0;
  endtask

  // One clock: sample handshake outputs mid-cycle and release granted requests.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (hdmi_gnt) begin hdmiGnts++; hdmi_req = 1'b0; end
    if (gpu_gnt) begin
      gpuGnts++;
      gpuGntCyc = cyc;
      if (!gpuHold) gpu_req = 1'b0;
    end
    if (hdmi_rvalid) begin hdmiRvs++; hdmiData = rdata; end
    if (gpu_rvalid) begin gpuRvs++; gpuData = rdata; gpuRvCyc = cyc; end
  endtask

  task automatic initMem();
    logic [DW-1:0] v;
    for (int i = 0; i < MW; i++) begin
      v = DW'(16'h1000 + i * 7);
      memArr[i] = v;
      refMem[i] = v;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            startCyc, bad, gIdx;
    logic          swapped, rBank, rDoH, rWe, rDone;
    logic [AW-1:0] rGa, rHa;
    logic [DW-1:0] rWd;
    logic [AW:0]   ea;

    reset = 1'b1; fbGPU = 1'b0; fbHDMI = 1'b0;
    hdmi_req = 1'b0; hdmi_addr = '0;
    gpu_req = 1'b0; gpu_we = 1'b0; gpu_addr = '0; gpu_wdata = '0;
    clear_start = 1'b0; clear_colour = '0;
    clearCounters();
    initMem();
    step(); step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_gnts", {hdmi_gnt, gpu_gnt}, 0);
    chk("rst_rvalids", {hdmi_rvalid, gpu_rvalid}, 0);
    reset = 1'b0;
    step();

    // HDMI and GPU reads raised together: HDMI first, each with its own bank.
    fixedAck = 1'b1; rdLat = 0; clearCounters(); txnLog.delete();
    fbHDMI = 1'b1; fbGPU = 1'b0;
    hdmi_addr = 4'hA; hdmi_req = 1'b1;
    gpu_addr = 4'h5; gpu_we = 1'b0; gpu_req = 1'b1;
    step();
    chk("lat_mem_req", mem_req, 1);
    chk("lat_hdmi_gnt", hdmiGnts, 1);
    chk("lat_mem_addr", mem_addr, 5'h1A);
    for (int i = 0; i < 30 && !(hdmiRvs == 1 && gpuRvs == 1); i++) step();
    step(); step();
    chk("pri_txn_count", txnLog.size(), 2);
    if (txnLog.size() == 2) begin
      chk("pri_first_addr", txnLog[0].addr, 5'h1A);
      chk("pri_second_addr", txnLog[1].addr, 5'h05);
    end
    chk("pri_gpu_gnts", gpuGnts, 1);
    chk("pri_hdmi_rvalids", hdmiRvs, 1);
    chk("pri_gpu_rvalids", gpuRvs, 1);
    chk("pri_hdmi_rdata", hdmiData, refMem[5'h1A]);
    chk("pri_gpu_rdata", gpuData, refMem[5'h05]);

    // GPU read, memory answers 0xBEEF two cycles after the ack.
    clearCounters(); txnLog.delete(); rdLat = 1; fbGPU = 1'b0;
    memArr[5'h05] = 16'hBEEF;
    gpu_addr = 4'h5; gpu_we = 1'b0; gpu_req = 1'b1;
    for (int i = 0; i < 20 && gpuRvs == 0; i++) step();
    step(); step(); step();
    chk("beef_gpu_rvalids", gpuRvs, 1);
    chk("beef_hdmi_rvalids", hdmiRvs, 0);
    chk("beef_rdata", gpuData, 16'hBEEF);
    chk("beef_latency", gpuRvCyc - gpuGntCyc, 2);
    injectSpurious = 1'b1;
    step(); step(); step();
    chk("spurious_rvalid_ignored", gpuRvs + hdmiRvs, 1);

    // Uncontended clear, with a restart attempt and bank swap mid-way.
    rdLat = 0; clearCounters(); txnLog.delete(); fbGPU = 1'b1;
    clear_colour = 16'h1234; clear_start = 1'b1; startCyc = cyc;
    step();
    clear_start = 1'b0;
    chk("clr_busy_set", clear_busy, 1);
    for (int i = 0; i < 100 && txnLog.size() < 5; i++) step();
    clear_colour = 16'h5555; clear_start = 1'b1; fbGPU = 1'b0;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 100 && clear_busy; i++) step();
    chk("clr_busy_fell", clear_busy, 0);
    chk("clr_min_cycles", (cyc - startCyc) >= 32, 1);
    step(); step();
    chk("clr_txn_count", txnLog.size(), 16);
    bad = 0;
    foreach (txnLog[i]) begin
      ea = {1'b1, AW'(i)};
      if (!(txnLog[i].we === 1'b1 && txnLog[i].addr === ea && txnLog[i].wdata === 16'h1234)) bad++;
    end
    chk("clr_bad_entries", bad, 0);

    // Reset while a clear write sits in ISSUE.
    noAck = 1'b1; clearCounters(); txnLog.delete(); fbGPU = 1'b0;
    clear_colour = 16'h7777; clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("rstmid_mem_req_high", mem_req, 1);
    chk("rstmid_mem_addr", mem_addr, 5'h00);
    reset = 1'b1;
    #1;
    chk("rstmid_mem_req_drop", mem_req, 0);
    chk("rstmid_busy_drop", clear_busy, 0);
    chk("rstmid_gnts", {hdmi_gnt, gpu_gnt}, 0);
    step(); step();
    reset = 1'b0; noAck = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rstmid_no_txn", txnLog.size(), 0);
    chk("rstmid_no_gnt", hdmiGnts + gpuGnts, 0);
    chk("rstmid_idle", {mem_req, clear_busy}, 0);

    // Clear racing a continuously held GPU write: strict alternation, GPU first.
    clearCounters(); txnLog.delete(); fbGPU = 1'b1; swapped = 1'b0;
    gpuHold = 1'b1; gpu_we = 1'b1; gpu_addr = 4'h7; gpu_wdata = 16'hAAAA; gpu_req = 1'b1;
    clear_colour = 16'h1234; clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 200 && clear_busy; i++) begin
      step();
      if (txnLog.size() >= 8 && !swapped) begin fbGPU = 1'b0; swapped = 1'b1; end
    end
    gpuHold = 1'b0; gpu_req = 1'b0;
    step(); step(); step();
    chk("rr_busy_fell", clear_busy, 0);
    chk("rr_txn_count", txnLog.size(), 32);
    if (txnLog.size() == 32) begin
      chk("rr_first_gpu", txnLog[0].wdata, 16'hAAAA);
      chk("rr_first_gpu_bank", txnLog[0].addr[AW], 1);
      chk("rr_last_gpu_bank", txnLog[30].addr[AW], 0);
      bad = 0;
      foreach (txnLog[i]) begin
        if (i % 2 == 0) begin
          if (!(txnLog[i].wdata === 16'hAAAA && txnLog[i].addr[AW-1:0] === 4'h7)) bad++;
        end else begin
          ea = {1'b1, AW'((i - 1) / 2)};
          if (!(txnLog[i].wdata === 16'h1234 && txnLog[i].addr === ea)) bad++;
        end
      end
      chk("rr_alternation", bad, 0);
    end
    chk("rr_gpu_gnts", gpuGnts, 16);

    // Randomized traffic with random memory latency.
    fixedAck = 1'b0; rdLat = -1; initMem();
    for (int t = 0; t < 30; t++) begin
      rBank = 1'($urandom_range(0, 1));
      rDoH = 1'($urandom_range(0, 1));
      rWe = 1'($urandom_range(0, 1));
      rGa = AW'($urandom);
      rHa = AW'($urandom);
      rWd = DW'($urandom);
      clearCounters(); txnLog.delete();
      fbGPU = rBank; fbHDMI = ~rBank;
      gpu_we = rWe; gpu_addr = rGa; gpu_wdata = rWd; gpu_req = 1'b1;
      if (rDoH) begin hdmi_addr = rHa; hdmi_req = 1'b1; end
      rDone = 1'b0;
      for (int i = 0; i < 60 && !rDone; i++) begin
        step();
        rDone = (gpuGnts == 1) && (rWe || gpuRvs == 1) && (!rDoH || hdmiRvs == 1);
      end
      step(); step();
      chk("rnd_done", rDone, 1);
      chk("rnd_txn_count", txnLog.size(), 1 + int'(rDoH));
      gIdx = rDoH ? 1 : 0;
      if (txnLog.size() == 1 + int'(rDoH)) begin
        chk("rnd_gpu_addr", txnLog[gIdx].addr, {rBank, rGa});
        chk("rnd_gpu_we", txnLog[gIdx].we, rWe);
        if (rWe) chk("rnd_gpu_wdata", txnLog[gIdx].wdata, rWd);
        if (rDoH) chk("rnd_hdmi_addr", txnLog[0].addr, {~rBank, rHa});
      end
      chk("rnd_gpu_rvalids", gpuRvs, rWe ? 0 : 1);
      chk("rnd_hdmi_rvalids", hdmiRvs, int'(rDoH));
      if (!rWe) chk("rnd_gpu_rdata", gpuData, refMem[{rBank, rGa}]);
      if (rDoH) chk("rnd_hdmi_rdata", hdmiData, refMem[{~rBank, rHa}]);
      if (rWe) refMem[{rBank, rGa}] = rWd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
